bypass_ctrl: RTL and testbench
==============================

Name: bypass_ctrl

Overview:
- Control-side driver of the bypass interface: owns the `control` modport and drives the `Bypass_line_ctrl` forwarding selects consumed by the execute-stage operand muxes.
- Keeps a two-entry in-flight scoreboard of recently issued writers and compares each issuing instruction's sources against it.
- Registers the forwarding selects for the consumer's execute cycle and raises a one-cycle stall on load-use hazards.
- Sits beside the issue stage, between decode/issue control and the ALU operand multiplexers.

Parameters:
- REG_ADDR_W, 5, width of a GPR address.
- STALL_CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction for issue.
- issue_src_a  input  REG_ADDR_W  operand A source register.
- issue_src_b  input  REG_ADDR_W  operand B source register.
- issue_use_a  input  1  operand A is read from the GPR file.
- issue_use_b  input  1  operand B is read from the GPR file.
- issue_dest  input  REG_ADDR_W  destination register.
- issue_dest_we  input  1  instruction writes issue_dest.
- issue_is_load  input  1  result comes from the load/store unit.
- flush  input  1  pipeline flush (branch mispredict or exception).
- stall  output  1  issue blocked this cycle (combinational).
- stall_count  output  STALL_CNT_W  saturating count of stall cycles.
- ctrl  interface  Bypass_if.control  drives lines.alu_to_alu_a/b and lines.ls_to_alu_a/b.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, named reset.
  - On reset: scoreboard entries e1 and e2 invalid, all ctrl.lines fields 0, stall_count 0.
  - stall is combinational and reads 0 while the entries are invalid.
- Acceptance: an issue is accepted when issue_valid & ~stall & ~flush.
- Scoreboard update, each cycle:
  - e2 <= e1.
  - e1 <= {valid = accept & issue_dest_we, dest, is_load}.
  - A non-accepted cycle inserts a bubble (e1 invalid).
- Source match: a source x ∈ {a, b} matches entry e when issue_use_x & e.valid & e.dest == issue_src_x. Register 0 is not special-cased.
- Hazard, combinational: stall = issue_valid & ~flush & (src a or b matches e1 & e1.is_load).
- Forwarding decision, evaluated only on accepted issues:
  - e1 match, non-load → alu_to_alu_x.
  - e2 match, any type → ls_to_alu_x. ALU results travel through the LS stage.
  - e1 has priority over e2, so at most one of alu_to_alu_x / ls_to_alu_x is set per operand.
  - Sources that are issued ≥3 cycles earlier get no forwarding; the register file supplies them.
- Output timing:
  - ctrl.lines is registered, valid in the cycle after acceptance (the consumer's EX cycle).
  - It is cleared to 0 in any cycle following a non-accepted cycle.
  - Both operands may forward from the same entry in the same cycle (e.g. alu_to_alu_a and alu_to_alu_b both 1).
- Load-use sequence, load L at cycle t, dependent D presented at t+1:
  - stall = 1 at t+1.
  - D is accepted at t+2 against e2 = L.
  - ls_to_alu_x = 1 at t+3.
  - Exactly one stall cycle.
- Flush:
  - Same-cycle: suppresses acceptance and stall.
  - Next cycle: e1, e2 invalid and ctrl.lines = 0.
  - flush has priority over stall and issue.
- stall_count:
  - Increments each cycle stall = 1.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset mid-stall: the next cycle returns to the reset state. Pending hazards are dropped.

Decomposition:
- Pu_types (shared package):
  - Bypass_line_ctrl (already present).
  - New Bypass_sb_entry typedef {valid, dest, is_load}.
  - Constant BYPASS_SB_DEPTH = 2.
- Sub-module bypass_match: purely combinational comparison of one source against both entries, producing {fwd_alu, fwd_ls, hazard}. It is instantiated twice, for operands a and b.

Test Plan:
- ALU back-to-back: ALU writes r3 at t; ALU reads r3 as A at t+1 → alu_to_alu_a = 1 at t+2; other lines 0; stall never 1.
- Distance-2 forward: ALU writes r7 at t; unrelated instruction at t+1; reader of r7 as B at t+2 → ls_to_alu_b = 1 at t+3.
- Load-use: load to r5 at t; add r5, r5 at t+1:
  - stall = 1 only at t+1.
  - Accepted at t+2.
  - ls_to_alu_a = ls_to_alu_b = 1 at t+3.
  - stall_count = 1.
- Priority: ALU writes r2 at t and again at t+1; reader of r2 at t+2 → alu_to_alu_a = 1, ls_to_alu_a = 0.
- Flush: load to r4 at t; flush with dependent at t+1 → stall = 0 at t+1; lines all 0 at t+2; reader of r4 at t+2 gets no forwarding.
- Saturation and reset: force stall_count near all-ones and stall 3 cycles → holds all-ones. Assert reset mid-stall → stall_count = 0 and lines = 0 next cycle.

Source files
------------

// File: rtl/bypass_ctrl_pkg.sv
// bypass_ctrl_pkg: shared types and constants for the bypass forwarding control
package bypass_ctrl_pkg;
   localparam int BYPASS_REG_ADDR_W = 5;
   localparam int BYPASS_SB_DEPTH = 2;
   typedef struct packed {
      logic alu_to_alu_a;
      logic alu_to_alu_b;
      logic ls_to_alu_a;
      logic ls_to_alu_b;
   } Bypass_line_ctrl;
   typedef struct packed {
      logic valid;
      logic [BYPASS_REG_ADDR_W-1:0] dest;
      logic is_load;
   } Bypass_sb_entry;
endpackage

// File: rtl/bypass_ctrl_if.sv
// Bypass_if: forwarding selects from bypass control to the execute operand muxes
interface Bypass_if;
   import bypass_ctrl_pkg::*;
   Bypass_line_ctrl lines;
   modport control(output lines);
   modport execute(input lines);
endinterface

// File: rtl/bypass_ctrl_match.sv
// bypass_match: compares one issuing source against the two in-flight writers
module bypass_match
   import bypass_ctrl_pkg::*;
(
   input  logic                         use_src,
   input  logic [BYPASS_REG_ADDR_W-1:0] src,
   input  Bypass_sb_entry               e1,
   input  logic                         e2_valid,
   input  logic [BYPASS_REG_ADDR_W-1:0] e2_dest,
   output logic                         fwd_alu,
   output logic                         fwd_ls,
   output logic                         hazard
);
   logic m1, m2;
   assign m1 = use_src & e1.valid & (e1.dest == src);
   assign m2 = use_src & e2_valid & (e2_dest == src);
   // e1 wins over e2; a load in e1 cannot be forwarded yet and becomes a hazard
   assign fwd_alu = m1 & ~e1.is_load;
   assign fwd_ls  = ~m1 & m2;
   assign hazard  = m1 & e1.is_load;
endmodule

// File: rtl/bypass_ctrl.sv
// bypass_ctrl: scoreboard-based operand forwarding selects and load-use stall
module bypass_ctrl
   import bypass_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = BYPASS_REG_ADDR_W,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [REG_ADDR_W-1:0]  issue_src_a,
   input  logic [REG_ADDR_W-1:0]  issue_src_b,
   input  logic                   issue_use_a,
   input  logic                   issue_use_b,
   input  logic [REG_ADDR_W-1:0]  issue_dest,
   input  logic                   issue_dest_we,
   input  logic                   issue_is_load,
   input  logic                   flush,
   output logic                   stall,
   output logic [STALL_CNT_W-1:0] stall_count,
   Bypass_if.control              ctrl
);
   Bypass_sb_entry sb [BYPASS_SB_DEPTH];
   logic alu_a, alu_b, ls_a, ls_b, hz_a, hz_b, accept;
   bypass_match u_match_a (
      .use_src(issue_use_a), .src(issue_src_a), .e1(sb[0]),
      .e2_valid(sb[1].valid), .e2_dest(sb[1].dest),
      .fwd_alu(alu_a), .fwd_ls(ls_a), .hazard(hz_a)
   );
   bypass_match u_match_b (
      .use_src(issue_use_b), .src(issue_src_b), .e1(sb[0]),
      .e2_valid(sb[1].valid), .e2_dest(sb[1].dest),
      .fwd_alu(alu_b), .fwd_ls(ls_b), .hazard(hz_b)
   );
   assign stall  = issue_valid & ~flush & (hz_a | hz_b);
   assign accept = issue_valid & ~flush & ~stall;
   // Shift the writer scoreboard, register the selects for EX, count stall cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         sb[0]       <= '0;
         sb[1]       <= '0;
         ctrl.lines  <= '0;
         stall_count <= '0;
      end else begin
         sb[1]       <= flush ? '0 : sb[0];
         sb[0]       <= Bypass_sb_entry'{accept & issue_dest_we, issue_dest, issue_is_load};
         ctrl.lines  <= accept ? Bypass_line_ctrl'{alu_a, alu_b, ls_a, ls_b} : '0;
         stall_count <= (stall & ~&stall_count) ? stall_count + 1'b1 : stall_count;
      end
   end
endmodule

// File: tb/tb_bypass_ctrl.sv
// tb_bypass_ctrl: directed and randomized checks of bypass_ctrl against a cycle-log model
module tb_bypass_ctrl;
   import bypass_ctrl_pkg::*;
   logic clk = 0, reset = 1, issue_valid = 0, issue_use_a = 0, issue_use_b = 0;
   logic issue_dest_we = 0, issue_is_load = 0, flush = 0;
   logic [4:0] issue_src_a = 0, issue_src_b = 0, issue_dest = 0;
   logic stall, stall2;
   logic [31:0] stall_count;
   logic [1:0] stall_count2;
   Bypass_if if1();
   Bypass_if if2();
   bypass_ctrl dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_src_a(issue_src_a),
      .issue_src_b(issue_src_b), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
      .issue_dest(issue_dest), .issue_dest_we(issue_dest_we), .issue_is_load(issue_is_load),
      .flush(flush), .stall(stall), .stall_count(stall_count), .ctrl(if1)
   );
   bypass_ctrl #(.STALL_CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_src_a(issue_src_a),
      .issue_src_b(issue_src_b), .issue_use_a(issue_use_a), .issue_use_b(issue_use_b),
      .issue_dest(issue_dest), .issue_dest_we(issue_dest_we), .issue_is_load(issue_is_load),
      .flush(flush), .stall(stall2), .stall_count(stall_count2), .ctrl(if2)
   );
   always #5 clk = ~clk;
   int n_checks = 0, n_fail = 0, cyc = 2;
   // log of writers accepted in each cycle; a flush retroactively kills the previous cycle's writer
   bit log_v [2048];
   bit log_l [2048];
   logic [4:0] log_d [2048];
   logic obs_stall, exp_stall;
   logic [3:0] obs_lines, exp_lines;
   logic [31:0] obs_cnt, exp_cnt = 0;
   logic [1:0] obs_cnt2, exp_cnt2 = 0;
   function automatic bit near(bit u, logic [4:0] s);
      return u && log_v[cyc-1] && log_d[cyc-1] == s;
   endfunction
   function automatic bit far(bit u, logic [4:0] s);
      return u && log_v[cyc-2] && log_d[cyc-2] == s;
   endfunction
   task automatic step(input logic v, input logic [4:0] sa, sb, input logic ua, ub,
                       input logic [4:0] d, input logic we, ld, fl);
      bit acc;
      logic [3:0] l;
      issue_valid = v; issue_src_a = sa; issue_src_b = sb; issue_use_a = ua; issue_use_b = ub;
      issue_dest = d; issue_dest_we = we; issue_is_load = ld; flush = fl;
      @(negedge clk);
      obs_stall = stall;
      exp_stall = v && !fl && log_l[cyc-1] && (near(ua, sa) || near(ub, sb));
      acc = v && !fl && !exp_stall;
      l = {near(ua, sa), near(ub, sb), far(ua, sa) && !near(ua, sa), far(ub, sb) && !near(ub, sb)};
      if (reset) begin
         exp_lines = 0; exp_cnt = 0; exp_cnt2 = 0; log_v[cyc] = 0; log_v[cyc-1] = 0;
      end else begin
         exp_lines = acc ? l : 4'b0;
         if (exp_stall) exp_cnt = exp_cnt + 1;
         if (exp_stall && exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 1;
         log_v[cyc] = acc && we; log_d[cyc] = d; log_l[cyc] = ld;
         if (fl) log_v[cyc-1] = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
      obs_lines = if1.lines;
      obs_cnt = stall_count;
      obs_cnt2 = stall_count2;
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic test_reset();
      reset = 1;
      step(1, 5, 5, 1, 1, 5, 1, 1, 0);
      step(1, 5, 5, 1, 1, 5, 1, 1, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL reset_lines got %b want 0000", obs_lines); end
      n_checks++; if (obs_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", obs_cnt); end
      reset = 0;
   endtask
   task automatic test_alu_b2b();
      idle();
      step(1, 0, 0, 0, 0, 3, 1, 0, 0);
      step(1, 3, 9, 1, 0, 10, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b1000) begin n_fail++; $display("FAIL b2b_lines got %b want 1000", obs_lines); end
      step(1, 10, 10, 1, 1, 11, 1, 0, 0);
      n_checks++; if (obs_lines !== 4'b1100) begin n_fail++; $display("FAIL b2b_both got %b want 1100", obs_lines); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL b2b_bubble got %b want 0000", obs_lines); end
   endtask
   task automatic test_dist2();
      idle();
      step(1, 0, 0, 0, 0, 7, 1, 0, 0);
      step(1, 20, 21, 1, 1, 12, 1, 0, 0);
      step(1, 0, 7, 0, 1, 13, 1, 0, 0);
      n_checks++; if (obs_lines !== 4'b0001) begin n_fail++; $display("FAIL dist2_lines got %b want 0001", obs_lines); end
   endtask
   task automatic test_load_use();
      logic [31:0] c0;
      idle();
      c0 = obs_cnt;
      step(1, 0, 0, 0, 0, 5, 1, 1, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL lu_t_stall got %b want 0", obs_stall); end
      step(1, 5, 5, 1, 1, 6, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL lu_t1_stall got %b want 1", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL lu_t2_lines got %b want 0000", obs_lines); end
      step(1, 5, 5, 1, 1, 6, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL lu_t2_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0011) begin n_fail++; $display("FAIL lu_t3_lines got %b want 0011", obs_lines); end
      n_checks++; if (obs_cnt !== c0 + 1) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", obs_cnt, c0 + 1); end
   endtask
   task automatic test_priority();
      idle();
      step(1, 0, 0, 0, 0, 2, 1, 0, 0);
      step(1, 0, 0, 0, 0, 2, 1, 0, 0);
      step(1, 2, 0, 1, 0, 14, 1, 0, 0);
      n_checks++; if (obs_lines !== 4'b1000) begin n_fail++; $display("FAIL prio_lines got %b want 1000", obs_lines); end
   endtask
   task automatic test_flush();
      idle();
      step(1, 0, 0, 0, 0, 4, 1, 1, 0);
      step(1, 4, 0, 1, 0, 8, 1, 0, 1);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL flush_lines got %b want 0000", obs_lines); end
      step(1, 4, 4, 1, 1, 8, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL flush_next_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL flush_next_lines got %b want 0000", obs_lines); end
   endtask
   task automatic test_sat_reset();
      reset = 1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 5, 1, 1, 0);
         step(1, 5, 0, 1, 0, 6, 1, 0, 0);
         step(1, 5, 0, 1, 0, 6, 1, 0, 0);
      end
      n_checks++; if (obs_cnt !== 32'd4) begin n_fail++; $display("FAIL sat_cnt32 got %0d want 4", obs_cnt); end
      n_checks++; if (obs_cnt2 !== 2'b11) begin n_fail++; $display("FAIL sat_cnt2 got %0d want 3", obs_cnt2); end
      step(1, 0, 0, 0, 0, 6, 1, 1, 0);
      reset = 1;
      step(1, 6, 0, 1, 0, 7, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL midstall_stall got %b want 1", obs_stall); end
      n_checks++; if (obs_cnt !== 32'd0) begin n_fail++; $display("FAIL midstall_cnt got %0d want 0", obs_cnt); end
      n_checks++; if (obs_cnt2 !== 2'd0) begin n_fail++; $display("FAIL midstall_cnt2 got %0d want 0", obs_cnt2); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL midstall_lines got %b want 0000", obs_lines); end
      reset = 0;
      step(1, 6, 0, 1, 0, 7, 1, 0, 0);
      n_checks++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL postreset_stall got %b want 0", obs_stall); end
      n_checks++; if (obs_lines !== 4'b0) begin n_fail++; $display("FAIL postreset_lines got %b want 0000", obs_lines); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              1'($urandom), $urandom_range(0, 7) == 0);
         n_checks++; if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, obs_stall, exp_stall); end
         n_checks++; if (obs_lines !== exp_lines) begin n_fail++; $display("FAIL rand_lines cyc %0d got %b want %b", cyc, obs_lines, exp_lines); end
         n_checks++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", cyc, obs_cnt, exp_cnt); end
         n_checks++; if (obs_cnt2 !== exp_cnt2) begin n_fail++; $display("FAIL rand_cnt2 cyc %0d got %0d want %0d", cyc, obs_cnt2, exp_cnt2); end
      end
   endtask
   initial begin
      test_reset();
      test_alu_b2b();
      test_dist2();
      test_load_use();
      test_priority();
      test_flush();
      test_sat_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
